// File: rtl/yacht_pkg.sv
// Shared constants for the Yacht scoring engine: category codes,
// response status codes and the FSM state encoding.
package yacht_pkg;

   localparam int N_CAT = 12;

   localparam logic [3:0] CAT_ACES   = 4'd0;
   localparam logic [3:0] CAT_TWOS   = 4'd1;
   localparam logic [3:0] CAT_THREES = 4'd2;
   localparam logic [3:0] CAT_FOURS  = 4'd3;
   localparam logic [3:0] CAT_FIVES  = 4'd4;
   localparam logic [3:0] CAT_SIXES  = 4'd5;
   localparam logic [3:0] CAT_CHOICE = 4'd6;
   localparam logic [3:0] CAT_FOUR_K = 4'd7;
   localparam logic [3:0] CAT_FULL_H = 4'd8;
   localparam logic [3:0] CAT_SSTR   = 4'd9;
   localparam logic [3:0] CAT_LSTR   = 4'd10;
   localparam logic [3:0] CAT_YACHT  = 4'd11;

   localparam logic [1:0] ST_OK      = 2'd0;
   localparam logic [1:0] ST_USED    = 2'd1;
   localparam logic [1:0] ST_BAD_CAT = 2'd2;
   localparam logic [1:0] ST_BAD_DIE = 2'd3;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_COUNT = 2'd1;
   localparam logic [1:0] S_EVAL  = 2'd2;
   localparam logic [1:0] S_RESP  = 2'd3;

endpackage

// File: rtl/yacht_score_engine_if.sv
// Request/response channel between the game controller (master) and
// the scoring engine (slave).
interface yacht_score_engine_if #(
   parameter int PID_W   = 1,
   parameter int SCORE_W = 8,
   parameter int TOTAL_W = 10
);
   logic               req_valid;
   logic               req_ready;
   logic [14:0]        req_dice;
   logic [PID_W-1:0]   req_player;
   logic [3:0]         req_cat;
   logic               req_commit;
   logic               rsp_valid;
   logic               rsp_ready;
   logic [SCORE_W-1:0] rsp_score;
   logic [1:0]         rsp_status;
   logic [TOTAL_W-1:0] rsp_total;
   logic               rsp_bonus;
   logic [11:0]        rsp_used_mask;

   modport master (
      output req_valid, req_dice, req_player, req_cat, req_commit, rsp_ready,
      input  req_ready, rsp_valid, rsp_score, rsp_status, rsp_total, rsp_bonus, rsp_used_mask
   );

   modport slave (
      input  req_valid, req_dice, req_player, req_cat, req_commit, rsp_ready,
      output req_ready, rsp_valid, rsp_score, rsp_status, rsp_total, rsp_bonus, rsp_used_mask
   );
endinterface

// File: rtl/yacht_cat_eval.sv
// Combinational category rule: turns a face histogram and dice sum
// into the score for one category.
module yacht_cat_eval
   import yacht_pkg::*;
#(
   parameter int SCORE_W     = 8,
   parameter int SS_SCORE    = 15,
   parameter int LS_SCORE    = 30,
   parameter int YACHT_SCORE = 50
) (
   input  logic [5:0][2:0]     hist,   // hist[f] = count of face f+1
   input  logic [5:0]          sum,
   input  logic [3:0]          cat,
   output logic [SCORE_W-1:0]  score
);
   logic [5:0]         present;
   logic               has2;
   logic               has3;
   logic               has5;
   logic [SCORE_W-1:0] upper_score;
   logic [SCORE_W-1:0] four_score;
   logic               small_str;
   logic               large_str;

   // Scan the histogram once for the pattern flags used by the rules
   always_comb begin
      present     = '0;
      has2        = 1'b0;
      has3        = 1'b0;
      has5        = 1'b0;
      upper_score = '0;
      four_score  = '0;
      for (int f = 0; f < 6; f++) begin
         present[f] = (hist[f] != 3'd0);
         has2 = has2 | (hist[f] == 3'd2);
         has3 = has3 | (hist[f] == 3'd3);
         has5 = has5 | (hist[f] == 3'd5);
         if (hist[f] >= 3'd4)
            four_score = SCORE_W'(4 * (f + 1));
         if (cat == 4'(f))
            upper_score = SCORE_W'(int'(hist[f]) * (f + 1));
      end
   end

   assign small_str = (&present[3:0]) | (&present[4:1]) | (&present[5:2]);
   assign large_str = (&present[4:0]) | (&present[5:1]);

   // Select the rule for the requested category
   always_comb begin
      score = '0;
      case (cat)
         CAT_ACES, CAT_TWOS, CAT_THREES,
         CAT_FOURS, CAT_FIVES, CAT_SIXES: score = upper_score;
         CAT_CHOICE: score = SCORE_W'(sum);
         CAT_FOUR_K: score = four_score;
         CAT_FULL_H: if ((has3 && has2) || has5) score = SCORE_W'(sum);
         CAT_SSTR:   if (small_str) score = SCORE_W'(SS_SCORE);
         CAT_LSTR:   if (large_str) score = SCORE_W'(LS_SCORE);
         CAT_YACHT:  if (has5) score = SCORE_W'(YACHT_SCORE);
         default:    score = '0;
      endcase
   end
endmodule

// File: rtl/yacht_score_engine.sv
// Multi-player Yacht scoring engine: histograms five dice one per cycle,
// evaluates the category, optionally commits to the player's scorecard
// and returns the result on a valid/ready response channel.
module yacht_score_engine
   import yacht_pkg::*;
#(
   parameter int N_PLAYERS    = 2,
   parameter int PID_W        = 1,
   parameter int SCORE_W      = 8,
   parameter int TOTAL_W      = 10,
   parameter int BONUS_THRESH = 63,
   parameter int BONUS_VAL    = 35,
   parameter int SS_SCORE     = 15,
   parameter int LS_SCORE     = 30,
   parameter int YACHT_SCORE  = 50
) (
   input  logic                 clk,
   input  logic                 rst_n,
   yacht_score_engine_if.slave  bus,
   input  logic                 game_clear,
   output logic [N_PLAYERS-1:0] card_full
);
   logic [1:0]         state;
   logic [2:0]         die_idx;
   logic [14:0]        dice;       // shifts right so die under test is always [2:0]
   logic [PID_W-1:0]   player;
   logic [3:0]         cat;
   logic               commit;
   logic [5:0][2:0]    hist;
   logic [5:0]         sum;
   logic               bad_die;
   logic [SCORE_W-1:0] score_hold;
   logic [1:0]         status_hold;

   logic [11:0]        used  [N_PLAYERS];
   logic [6:0]         upper [N_PLAYERS];
   logic [TOTAL_W-1:0] total [N_PLAYERS];
   logic               bonus [N_PLAYERS];

   logic [11:0]        used_sel;
   logic [6:0]         upper_sel;
   logic [TOTAL_W-1:0] total_sel;
   logic               bonus_sel;
   logic [SCORE_W-1:0] eval_score;
   logic [1:0]         status;
   logic               do_commit;
   logic [6:0]         new_upper;
   logic               bonus_hit;
   logic [TOTAL_W-1:0] new_total;
   logic [2:0]         die;

   assign die           = dice[2:0];
   assign bus.req_ready = (state == S_IDLE) && !game_clear;

   yacht_cat_eval #(
      .SCORE_W     (SCORE_W),
      .SS_SCORE    (SS_SCORE),
      .LS_SCORE    (LS_SCORE),
      .YACHT_SCORE (YACHT_SCORE)
   ) u_eval (
      .hist  (hist),
      .sum   (sum),
      .cat   (cat),
      .score (eval_score)
   );

   // Pick out the scorecard of the player in the current transaction
   always_comb begin
      used_sel  = '0;
      upper_sel = '0;
      total_sel = '0;
      bonus_sel = 1'b0;
      for (int p = 0; p < N_PLAYERS; p++) begin
         if (player == PID_W'(p)) begin
            used_sel  = used[p];
            upper_sel = upper[p];
            total_sel = total[p];
            bonus_sel = bonus[p];
         end
      end
   end

   // Status priority: bad die, then bad category, then reused category on commit
   always_comb begin
      if (bad_die)
         status = ST_BAD_DIE;
      else if (cat >= 4'(N_CAT))
         status = ST_BAD_CAT;
      else if (commit && used_sel[cat])
         status = ST_USED;
      else
         status = ST_OK;
   end

   // Next scorecard values for a commit; the bonus is granted only once
   always_comb begin
      do_commit = (state == S_EVAL) && commit && (status == ST_OK);
      new_upper = upper_sel;
      if (cat < CAT_CHOICE)
         new_upper = upper_sel + 7'(eval_score);
      bonus_hit = !bonus_sel && (cat < CAT_CHOICE) &&
                  (32'(new_upper) >= 32'(BONUS_THRESH));
      new_total = total_sel + TOTAL_W'(eval_score) +
                  (bonus_hit ? TOTAL_W'(BONUS_VAL) : TOTAL_W'(0));
   end

   // Transaction FSM: accept, count dice, evaluate, respond
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state             <= S_IDLE;
         die_idx           <= '0;
         dice              <= '0;
         player            <= '0;
         cat               <= '0;
         commit            <= 1'b0;
         hist              <= '0;
         sum               <= '0;
         bad_die           <= 1'b0;
         score_hold        <= '0;
         status_hold       <= ST_OK;
         bus.rsp_valid     <= 1'b0;
         bus.rsp_score     <= '0;
         bus.rsp_status    <= ST_OK;
         bus.rsp_total     <= '0;
         bus.rsp_bonus     <= 1'b0;
         bus.rsp_used_mask <= '0;
      end else if (game_clear) begin
         state         <= S_IDLE;
         bus.rsp_valid <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.req_valid) begin
                  dice    <= bus.req_dice;
                  player  <= bus.req_player;
                  cat     <= bus.req_cat;
                  commit  <= bus.req_commit;
                  hist    <= '0;
                  sum     <= '0;
                  bad_die <= 1'b0;
                  die_idx <= '0;
                  state   <= S_COUNT;
               end
            end
            S_COUNT: begin
               if (die == 3'd0 || die == 3'd7) begin
                  bad_die <= 1'b1;
               end else begin
                  for (int f = 0; f < 6; f++)
                     if (die == 3'(f + 1))
                        hist[f] <= hist[f] + 3'd1;
                  sum <= sum + 6'(die);
               end
               dice    <= dice >> 3;
               die_idx <= die_idx + 3'd1;
               if (die_idx == 3'd4)
                  state <= S_EVAL;
            end
            S_EVAL: begin
               score_hold  <= (status == ST_OK) ? eval_score : '0;
               status_hold <= status;
               state       <= S_RESP;
            end
            S_RESP: begin
               // First RESP cycle loads the post-commit scorecard view
               if (!bus.rsp_valid) begin
                  bus.rsp_valid     <= 1'b1;
                  bus.rsp_score     <= score_hold;
                  bus.rsp_status    <= status_hold;
                  bus.rsp_total     <= total_sel;
                  bus.rsp_bonus     <= bonus_sel;
                  bus.rsp_used_mask <= used_sel;
               end else if (bus.rsp_ready) begin
                  bus.rsp_valid <= 1'b0;
                  state         <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Scorecard storage; clear wins over a same-cycle commit
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int p = 0; p < N_PLAYERS; p++) begin
            used[p]  <= '0;
            upper[p] <= '0;
            total[p] <= '0;
            bonus[p] <= 1'b0;
         end
      end else if (game_clear) begin
         for (int p = 0; p < N_PLAYERS; p++) begin
            used[p]  <= '0;
            upper[p] <= '0;
            total[p] <= '0;
            bonus[p] <= 1'b0;
         end
      end else if (do_commit) begin
         for (int p = 0; p < N_PLAYERS; p++) begin
            if (player == PID_W'(p)) begin
               used[p]  <= used_sel | (12'd1 << cat);
               upper[p] <= new_upper;
               total[p] <= new_total;
               if (bonus_hit)
                  bonus[p] <= 1'b1;
            end
         end
      end
   end

   for (genvar gi = 0; gi < N_PLAYERS; gi++) begin : g_full
      assign card_full[gi] = &used[gi];
   end
endmodule

// File: tb/tb_yacht_score_engine.sv
// Self-checking bench for yacht_score_engine with a sort/count based
// reference model of the Yacht rules and scorecards.
module tb_yacht_score_engine;
   localparam int NP = 2;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          game_clear = 1'b0;
   logic [NP-1:0] card_full;

   yacht_score_engine_if #(.PID_W(1), .SCORE_W(8), .TOTAL_W(10)) bus ();

   yacht_score_engine #(.N_PLAYERS(NP)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus        (bus),
      .game_clear (game_clear),
      .card_full  (card_full)
   );

   always #5 clk = ~clk;

   int n_total = 0;
   int n_bad   = 0;

   // reference scorecards
   int          m_upper [NP];
   int          m_tot   [NP];
   bit          m_bonus [NP];
   logic [11:0] m_used  [NP];

   function automatic int ref_score(input int d[5], input int cat);
      int s[5];
      int cnt[8];
      int sum;
      int pres;
      int t;
      int r;
      sum = 0; pres = 0; r = 0;
      for (int i = 0; i < 8; i++) cnt[i] = 0;
      for (int i = 0; i < 5; i++) begin
         s[i] = d[i];
         cnt[d[i]]++;
         sum += d[i];
         pres |= (1 << d[i]);
      end
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4 - i; j++)
            if (s[j] > s[j+1]) begin t = s[j]; s[j] = s[j+1]; s[j+1] = t; end
      case (cat)
         0, 1, 2, 3, 4, 5: r = cnt[cat+1] * (cat + 1);
         6: r = sum;
         7: for (int f = 1; f <= 6; f++) if (cnt[f] >= 4) r = 4 * f;
         8: if (s[0] == s[4] || (s[0] == s[2] && s[3] == s[4]) ||
                (s[0] == s[1] && s[2] == s[4])) r = sum;
         9: if ((pres & 'h1e) == 'h1e || (pres & 'h3c) == 'h3c ||
                (pres & 'h78) == 'h78) r = 15;
         10: if ((pres & 'h3e) == 'h3e || (pres & 'h7c) == 'h7c) r = 30;
         11: if (s[0] == s[4]) r = 50;
         default: r = 0;
      endcase
      return r;
   endfunction

   task automatic model_clear();
      for (int p = 0; p < NP; p++) begin
         m_upper[p] = 0; m_tot[p] = 0; m_bonus[p] = 0; m_used[p] = '0;
      end
   endtask

   task automatic model_txn(input int d[5], input int pl, input int cat, input int cm,
                            output int st, output int sc, output int tot,
                            output int bon, output int used);
      bit bad_d;
      bad_d = 0;
      sc = 0;
      for (int i = 0; i < 5; i++) if (d[i] < 1 || d[i] > 6) bad_d = 1;
      if (bad_d) st = 3;
      else if (cat >= 12) st = 2;
      else if (cm != 0 && m_used[pl][cat]) st = 1;
      else begin
         st = 0;
         sc = ref_score(d, cat);
         if (cm != 0) begin
            m_used[pl][cat] = 1'b1;
            m_tot[pl] += sc;
            if (cat < 6) begin
               m_upper[pl] += sc;
               if (!m_bonus[pl] && m_upper[pl] >= 63) begin
                  m_bonus[pl] = 1;
                  m_tot[pl] += 35;
               end
            end
         end
      end
      tot = m_tot[pl];
      bon = int'(m_bonus[pl]);
      used = int'(m_used[pl]);
   endtask

   task automatic txn_issue(input int d[5], input int pl, input int cat, input int cm,
                            output int lat);
      @(negedge clk);
      bus.req_dice   = {3'(d[4]), 3'(d[3]), 3'(d[2]), 3'(d[1]), 3'(d[0])};
      bus.req_player = 1'(pl);
      bus.req_cat    = 4'(cat);
      bus.req_commit = 1'(cm);
      bus.req_valid  = 1'b1;
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      lat = 0;
      while (bus.rsp_valid !== 1'b1 && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic txn_finish();
      bus.rsp_ready = 1'b1;
      @(posedge clk); #1;
      bus.rsp_ready = 1'b0;
   endtask

   task automatic txn(input int d[5], input int pl, input int cat, input int cm,
                      output int lat, output int sc, output int st, output int tot,
                      output int bon, output int used);
      txn_issue(d, pl, cat, cm, lat);
      sc = int'(bus.rsp_score); st = int'(bus.rsp_status); tot = int'(bus.rsp_total);
      bon = int'(bus.rsp_bonus); used = int'(bus.rsp_used_mask);
      txn_finish();
      $display("txn p=%0d cat=%0d commit=%0d dice=%0d%0d%0d%0d%0d -> lat=%0d score=%0d status=%0d total=%0d bonus=%0d used=%03h",
               pl, cat, cm, d[0], d[1], d[2], d[3], d[4], lat, sc, st, tot, bon, used);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.req_valid = 0; bus.req_dice = '0; bus.req_player = '0;
      bus.req_cat = '0; bus.req_commit = 0; bus.rsp_ready = 0;
      model_clear();
      repeat (3) @(posedge clk);
      #1;
      n_total++;
      if (bus.rsp_valid !== 1'b0 || bus.rsp_score !== 8'd0 || bus.rsp_status !== 2'd0 ||
          bus.rsp_total !== 10'd0 || bus.rsp_bonus !== 1'b0 || bus.rsp_used_mask !== 12'd0 ||
          card_full !== 2'b00) begin
         $display("FAIL reset_outputs: valid=%b score=%0d status=%0d total=%0d bonus=%b used=%h full=%b, need all zero",
                  bus.rsp_valid, bus.rsp_score, bus.rsp_status, bus.rsp_total, bus.rsp_bonus,
                  bus.rsp_used_mask, card_full);
         n_bad++;
      end
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      n_total++;
      if (bus.req_ready !== 1'b1) begin
         $display("FAIL reset_ready: req_ready=%b need 1", bus.req_ready); n_bad++;
      end
   endtask

   task automatic test_full_house();
      int d[5];
      int lat, sc, st, tot, bon, used, es, esc, et, eb, eu;
      d = '{3, 3, 3, 5, 5};
      model_txn(d, 0, 8, 1, es, esc, et, eb, eu);
      txn(d, 0, 8, 1, lat, sc, st, tot, bon, used);
      n_total++;
      if (lat !== 7 || sc !== 19 || st !== 0 || tot !== 19 || used !== 'h100 || bon !== 0) begin
         $display("FAIL full_house: lat=%0d score=%0d st=%0d total=%0d used=%h bonus=%0d need 7/19/0/19/100/0",
                  lat, sc, st, tot, used, bon);
         n_bad++;
      end
   endtask

   task automatic test_preview();
      int d[5];
      int cats[3];
      int exp_sc[3];
      int lat, sc, st, tot, bon, used;
      d = '{1, 2, 3, 4, 6};
      cats = '{9, 10, 7};
      exp_sc = '{15, 0, 0};
      for (int i = 0; i < 3; i++) begin
         txn(d, 0, cats[i], 0, lat, sc, st, tot, bon, used);
         n_total++;
         if (lat !== 7 || sc !== exp_sc[i] || st !== 0 || tot !== 19 || used !== 'h100) begin
            $display("FAIL preview cat=%0d: lat=%0d score=%0d st=%0d total=%0d used=%h need 7/%0d/0/19/100",
                     cats[i], lat, sc, st, tot, used, exp_sc[i]);
            n_bad++;
         end
      end
   endtask

   task automatic test_bonus();
      int d[5];
      int lat, sc, st, tot, bon, used, es, esc, et, eb, eu;
      for (int f = 1; f <= 6; f++) begin
         d = '{f, f, f, (f % 6) + 1, (f % 6) + 1};
         model_txn(d, 1, f - 1, 1, es, esc, et, eb, eu);
         txn(d, 1, f - 1, 1, lat, sc, st, tot, bon, used);
         n_total++;
         if (lat !== 7 || sc !== 3 * f || st !== es || tot !== et || bon !== eb ||
             used !== eu || (f == 6 && (tot !== 98 || bon !== 1)) || (f < 6 && bon !== 0)) begin
            $display("FAIL bonus face=%0d: score=%0d st=%0d total=%0d bonus=%0d used=%h need %0d/%0d/%0d/%0d/%h",
                     f, sc, st, tot, bon, used, 3 * f, es, et, eb, eu);
            n_bad++;
         end
      end
      d = '{1, 1, 1, 1, 1};
      txn(d, 0, 6, 0, lat, sc, st, tot, bon, used);
      n_total++;
      if (sc !== 5 || tot !== 19 || bon !== 0 || used !== 'h100) begin
         $display("FAIL bonus_isolation: score=%0d total=%0d bonus=%0d used=%h need 5/19/0/100",
                  sc, tot, bon, used);
         n_bad++;
      end
   endtask

   task automatic test_errors();
      int d[5];
      int pat[5][5];
      int cats[5];
      int cms[5];
      int lat, sc, st, tot, bon, used, es, esc, et, eb, eu;
      pat = '{'{3, 3, 3, 5, 5}, '{0, 1, 2, 3, 4}, '{1, 2, 3, 4, 5}, '{7, 2, 2, 2, 2}, '{3, 3, 3, 5, 5}};
      cats = '{8, 6, 13, 13, 8};
      cms  = '{1, 1, 1, 1, 0};
      for (int i = 0; i < 5; i++) begin
         d = pat[i];
         model_txn(d, 0, cats[i], cms[i], es, esc, et, eb, eu);
         txn(d, 0, cats[i], cms[i], lat, sc, st, tot, bon, used);
         n_total++;
         if (lat !== 7 || sc !== esc || st !== es || tot !== et || bon !== eb || used !== eu) begin
            $display("FAIL error_case %0d: score=%0d st=%0d total=%0d bonus=%0d used=%h need %0d/%0d/%0d/%0d/%h",
                     i, sc, st, tot, bon, used, esc, es, et, eb, eu);
            n_bad++;
         end
      end
   endtask

   task automatic test_backpressure();
      int d[5];
      int lat, es, esc, et, eb, eu;
      logic [7:0]  h_sc;
      logic [1:0]  h_st;
      logic [9:0]  h_tot;
      logic        h_bon;
      logic [11:0] h_used;
      d = '{6, 5, 4, 3, 2};
      model_txn(d, 0, 6, 0, es, esc, et, eb, eu);
      txn_issue(d, 0, 6, 0, lat);
      h_sc = bus.rsp_score; h_st = bus.rsp_status; h_tot = bus.rsp_total;
      h_bon = bus.rsp_bonus; h_used = bus.rsp_used_mask;
      $display("txn p=0 cat=6 commit=0 held -> lat=%0d score=%0d status=%0d total=%0d",
               lat, h_sc, h_st, h_tot);
      n_total++;
      if (lat !== 7 || int'(h_sc) !== esc || int'(h_st) !== es || int'(h_tot) !== et) begin
         $display("FAIL hold_value: lat=%0d score=%0d st=%0d total=%0d need 7/%0d/%0d/%0d",
                  lat, h_sc, h_st, h_tot, esc, es, et);
         n_bad++;
      end
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #1;
         n_total++;
         if (bus.rsp_valid !== 1'b1 || bus.req_ready !== 1'b0 || bus.rsp_score !== h_sc ||
             bus.rsp_status !== h_st || bus.rsp_total !== h_tot || bus.rsp_bonus !== h_bon ||
             bus.rsp_used_mask !== h_used) begin
            $display("FAIL hold_stable cyc=%0d: valid=%b ready=%b score=%0d total=%0d need 1/0/%0d/%0d",
                     c, bus.rsp_valid, bus.req_ready, bus.rsp_score, bus.rsp_total, h_sc, h_tot);
            n_bad++;
         end
      end
      txn_finish();
      n_total++;
      if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
         $display("FAIL hold_release: req_ready=%b rsp_valid=%b need 1/0", bus.req_ready, bus.rsp_valid);
         n_bad++;
      end
   endtask

   task automatic test_clear();
      int d[5];
      int lat, sc, st, tot, bon, used;
      bit seen;
      @(negedge clk);
      bus.req_dice = {3'd6, 3'd6, 3'd6, 3'd6, 3'd6};
      bus.req_player = 1'b1; bus.req_cat = 4'd11; bus.req_commit = 1'b1; bus.req_valid = 1'b1;
      @(negedge clk);
      bus.req_valid = 1'b0;
      @(negedge clk);
      game_clear = 1'b1;
      #1;
      n_total++;
      if (bus.req_ready !== 1'b0) begin
         $display("FAIL clear_ready: req_ready=%b need 0", bus.req_ready); n_bad++;
      end
      @(negedge clk);
      game_clear = 1'b0;
      model_clear();
      seen = 0;
      for (int c = 0; c < 12; c++) begin
         @(posedge clk); #1;
         if (bus.rsp_valid === 1'b1) seen = 1;
      end
      n_total++;
      if (seen || card_full !== 2'b00) begin
         $display("FAIL clear_abort: response_seen=%0d card_full=%b need 0/00", seen, card_full);
         n_bad++;
      end
      d = '{2, 2, 2, 2, 2};
      for (int p = 0; p < NP; p++) begin
         txn(d, p, 1, 0, lat, sc, st, tot, bon, used);
         n_total++;
         if (sc !== 10 || st !== 0 || tot !== 0 || bon !== 0 || used !== 0) begin
            $display("FAIL clear_card p=%0d: score=%0d st=%0d total=%0d bonus=%0d used=%h need 10/0/0/0/000",
                     p, sc, st, tot, bon, used);
            n_bad++;
         end
      end
   endtask

   task automatic test_card_full();
      int d[5];
      int lat, sc, st, tot, bon, used, es, esc, et, eb, eu;
      for (int c = 0; c < 12; c++) begin
         for (int i = 0; i < 5; i++) d[i] = int'($urandom_range(1, 6));
         model_txn(d, 0, c, 1, es, esc, et, eb, eu);
         txn(d, 0, c, 1, lat, sc, st, tot, bon, used);
         n_total++;
         if (lat !== 7 || sc !== esc || st !== es || tot !== et || bon !== eb || used !== eu ||
             card_full[0] !== (c == 11) || card_full[1] !== 1'b0) begin
            $display("FAIL card_fill cat=%0d: score=%0d st=%0d total=%0d used=%h full=%b need %0d/%0d/%0d/%h/%b",
                     c, sc, st, tot, used, card_full, esc, es, et, eu, (c == 11));
            n_bad++;
         end
      end
   endtask

   task automatic test_random();
      int d[5];
      int pl, cat, cm, r;
      int lat, sc, st, tot, bon, used, es, esc, et, eb, eu;
      @(negedge clk); game_clear = 1'b1;
      @(negedge clk); game_clear = 1'b0;
      model_clear();
      for (int t = 0; t < 40; t++) begin
         for (int i = 0; i < 5; i++) begin
            r = int'($urandom_range(0, 31));
            if (r == 0) d[i] = 0;
            else if (r == 1) d[i] = 7;
            else if (r < 14) d[i] = int'($urandom_range(3, 4));
            else d[i] = int'($urandom_range(1, 6));
         end
         pl  = int'($urandom_range(0, NP - 1));
         cat = int'($urandom_range(0, 13));
         cm  = int'($urandom_range(0, 3) != 0);
         model_txn(d, pl, cat, cm, es, esc, et, eb, eu);
         txn(d, pl, cat, cm, lat, sc, st, tot, bon, used);
         n_total++;
         if (lat !== 7 || sc !== esc || st !== es || tot !== et || bon !== eb || used !== eu) begin
            $display("FAIL random %0d: score=%0d st=%0d total=%0d bonus=%0d used=%h lat=%0d need %0d/%0d/%0d/%0d/%h/7",
                     t, sc, st, tot, bon, used, lat, esc, es, et, eb, eu);
            n_bad++;
         end
      end
   endtask

   initial begin
      test_reset();
      test_full_house();
      test_preview();
      test_bonus();
      test_errors();
      test_backpressure();
      test_clear();
      test_card_full();
      test_random();
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule
